// File: rtl/branch_sequencer.sv
// branch_sequencer
// Control-side sequencer for conditional branches: captures the branch
// instruction and PC+1, gates Ra onto the bus, strobes the CON flip-flop,
// samples the returned CON bit and loads the PC with the target or the
// fall-through address. All outputs are registered.
module branch_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int C_W     = 19,
    parameter int CON_LAT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [31:0]       ir_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              con,
    output logic              ra_out,
    output logic              con_en,
    output logic [3:0]        cond_field,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_load,
    output logic              taken,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ARM,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [2:0] LAT = 3'(CON_LAT);

    state_t            state;
    logic [2:0]        wait_cnt;
    logic [C_W-1:0]    disp_lat;
    logic [ADDR_W-1:0] pc_lat;
    logic [ADDR_W-1:0] target;
    logic              accept;
    logic              unused_ir_bits;

    // Instruction bits above the condition field carry nothing this block needs.
    assign unused_ir_bits = ^ir_in[31:23];

    // A request is taken only from IDLE, and never on a clearing edge.
    assign accept = (state == S_IDLE) && start && !clear;

    // Branch target: PC+1 plus the sign-extended displacement, modulo 2^ADDR_W.
    assign target = pc_lat + {{(ADDR_W - C_W){disp_lat[C_W-1]}}, disp_lat};

    // Operand capture on an accepted start.
    // NOTE: these are pure data registers qualified by the FSM; they need no
    // reset because nothing reads them until a capture has refreshed them.
    always_ff @(posedge clock) begin
        if (accept) begin
            disp_lat <= ir_in[C_W-1:0];
            pc_lat   <= pc_in;
        end
    end

    // Sequencing FSM with all handshake outputs registered.
    // NOTE: every state and output register here uses <=, so each edge sees
    // the values of the previous cycle regardless of statement order.
    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            ra_out     <= 1'b0;
            con_en     <= 1'b0;
            cond_field <= '0;
            pc_out     <= '0;
            pc_load    <= 1'b0;
            taken      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cond_field <= ir_in[22:19];
                        taken      <= 1'b0;
                        busy       <= 1'b1;
                        ra_out     <= 1'b1;   // bus settles during SETUP
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    con_en <= 1'b1;           // enable edge one cycle after Ra
                    state  <= S_ARM;
                end
                S_ARM: begin
                    wait_cnt <= LAT;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        // Last WAIT cycle: con is valid now and only now.
                        taken   <= con;
                        pc_out  <= con ? target : pc_lat;
                        pc_load <= 1'b1;
                        ra_out  <= 1'b0;
                        con_en  <= 1'b0;
                        state   <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    pc_load <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: two instances (CON_LAT=1 and CON_LAT=3) share
// instruction/PC/clear inputs; expected PC loads are queued at start and
// compared when each instance pulses pc_load.
module tb_branch_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        start_a, start_b, con_a, con_b;
    logic [31:0] ir_in, pc_in;

    logic        ra_out_a, con_en_a, pc_load_a, taken_a, busy_a, done_a;
    logic        ra_out_b, con_en_b, pc_load_b, taken_b, busy_b, done_b;
    logic [3:0]  cond_field_a, cond_field_b;
    logic [31:0] pc_out_a, pc_out_b;

    always #5 clock = ~clock;

    branch_sequencer #(.ADDR_W(32), .C_W(19), .CON_LAT(1)) dut_a (
        .clock(clock), .clear(clear), .start(start_a), .ir_in(ir_in),
        .pc_in(pc_in), .con(con_a), .ra_out(ra_out_a), .con_en(con_en_a),
        .cond_field(cond_field_a), .pc_out(pc_out_a), .pc_load(pc_load_a),
        .taken(taken_a), .busy(busy_a), .done(done_a)
    );

    branch_sequencer #(.ADDR_W(32), .C_W(19), .CON_LAT(3)) dut_b (
        .clock(clock), .clear(clear), .start(start_b), .ir_in(ir_in),
        .pc_in(pc_in), .con(con_b), .ra_out(ra_out_b), .con_en(con_en_b),
        .cond_field(cond_field_b), .pc_out(pc_out_b), .pc_load(pc_load_b),
        .taken(taken_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        int          base;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   errors = 0;
    int   checks = 0;
    int   pcnt = 0;
    int   last_base_a = 0, last_base_b = 0;
    int   loads_a = 0, loads_b = 0;
    int   exp_loads_a = 0, exp_loads_b = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [18:0] c);
        int disp;
        disp = int'($signed(c));
        return pc + 32'(disp);
    endfunction

    always @(posedge clock) pcnt++;

    // Scoreboard for instance A (CON_LAT=1): load at cycle 4, done at cycle 5.
    always @(negedge clock) begin
        if (pc_load_a) begin
            loads_a++;
            if (q_a.size() == 0) begin
                check("a_unexpected_pc_load", 1, 0);
            end else begin
                e_a = q_a.pop_front();
                check("a_pc_out", pc_out_a, e_a.pc);
                check("a_taken", taken_a, e_a.tk);
                check("a_load_cycle", pcnt - e_a.base, 4);
                last_base_a = e_a.base;
            end
        end
        if (done_a) begin
            check("a_done_cycle", pcnt - last_base_a, 5);
            check("a_busy_at_done", busy_a, 0);
        end
    end

    // Scoreboard for instance B (CON_LAT=3): load at cycle 6, done at cycle 7.
    always @(negedge clock) begin
        if (pc_load_b) begin
            loads_b++;
            if (q_b.size() == 0) begin
                check("b_unexpected_pc_load", 1, 0);
            end else begin
                e_b = q_b.pop_front();
                check("b_pc_out", pc_out_b, e_b.pc);
                check("b_taken", taken_b, e_b.tk);
                check("b_load_cycle", pcnt - e_b.base, 6);
                last_base_b = e_b.base;
            end
        end
        if (done_b) begin
            check("b_done_cycle", pcnt - last_base_b, 7);
            check("b_busy_at_done", busy_b, 0);
        end
    end

    // One branch on instance A; optionally hammer start while busy.
    task automatic run_a(input logic [31:0] pc, input logic [18:0] c, input logic cv,
                         input bit abuse);
        logic [31:0] exp_pc;
        logic [3:0]  cond;
        exp_pc = cv ? branch_target(pc, c) : pc;
        cond   = pc[3:0] ^ 4'h9;
        @(negedge clock);
        ir_in   = {9'h0, cond, c};
        pc_in   = pc;
        con_a   = cv;
        start_a = 1'b1;
        q_a.push_back('{pc: exp_pc, tk: cv, base: pcnt});
        exp_loads_a++;
        @(negedge clock);
        start_a = 1'b0;
        ir_in   = $urandom;
        pc_in   = $urandom;
        check("a_setup_ra", ra_out_a, 1);
        check("a_setup_con_en", con_en_a, 0);
        check("a_cond_field", cond_field_a, cond);
        check("a_busy", busy_a, 1);
        for (int i = 0; i < 20 && !done_a; i++) begin
            start_a = abuse && (i < 2);
            @(negedge clock);
        end
        start_a = 1'b0;
        check("a_done_seen", done_a, 1);
        con_a = ~cv;
        @(negedge clock);
        check("a_taken_held", taken_a, cv);
        check("a_pc_out_held", pc_out_a, exp_pc);
    endtask

    // One branch on instance B; con shows the opposite value until the last
    // WAIT cycle (cycle 5) and again afterwards, so only that cycle counts.
    task automatic run_b(input logic [31:0] pc, input logic [18:0] c, input logic fin);
        @(negedge clock);
        ir_in   = {9'h0, 4'h6, c};
        pc_in   = pc;
        con_b   = ~fin;
        start_b = 1'b1;
        q_b.push_back('{pc: fin ? branch_target(pc, c) : pc, tk: fin, base: pcnt});
        exp_loads_b++;
        @(negedge clock);
        start_b = 1'b0;
        ir_in   = $urandom;
        pc_in   = $urandom;
        check("b_c1_ra", ra_out_b, 1);
        check("b_c1_con_en", con_en_b, 0);
        @(negedge clock);
        check("b_c2_ra", ra_out_b, 1);
        check("b_c2_con_en", con_en_b, 1);
        @(negedge clock);
        @(negedge clock);
        check("b_c4_con_en", con_en_b, 1);
        @(negedge clock);
        con_b = fin;
        @(negedge clock);
        con_b = ~fin;
        check("b_c6_ra", ra_out_b, 0);
        for (int i = 0; i < 20 && !done_b; i++) @(negedge clock);
        check("b_done_seen", done_b, 1);
        @(negedge clock);
        check("b_taken_held", taken_b, fin);
    endtask

    function automatic logic [63:0] outs_a();
        return {22'h0, ra_out_a, con_en_a, cond_field_a, pc_out_a, pc_load_a, taken_a, busy_a, done_a};
    endfunction

    function automatic logic [63:0] outs_b();
        return {22'h0, ra_out_b, con_en_b, cond_field_b, pc_out_b, pc_load_b, taken_b, busy_b, done_b};
    endfunction

    initial begin
        clear   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        con_a   = 1'b0;
        con_b   = 1'b0;
        ir_in   = '0;
        pc_in   = '0;
        repeat (2) @(negedge clock);
        check("reset_a_outputs", outs_a(), 0);
        check("reset_b_outputs", outs_b(), 0);
        clear = 1'b0;

        run_a(32'h10, 19'd5, 1'b1, 1'b0);              // taken
        run_a(32'h10, 19'd5, 1'b0, 1'b0);              // not taken
        run_a(32'h3, 19'h7FFFA, 1'b1, 1'b0);           // negative displacement
        run_a(32'hFFFF_FFFF, 19'd2, 1'b1, 1'b0);       // wrap
        run_a(32'h0001_0000, 19'h40000, 1'b1, 1'b0);   // most negative displacement
        run_a(32'h20, 19'd7, 1'b1, 1'b1);              // start while busy
        run_b(32'h10, 19'd5, 1'b0);                    // late con toggle, not taken
        run_b(32'h40, 19'h7FFF0, 1'b1);                // late con toggle, taken

        // start on the same edge as clear: request dropped.
        @(negedge clock);
        clear   = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        ir_in   = 32'h0078_0001;
        pc_in   = 32'h1234;
        @(negedge clock);
        clear   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        check("clr_start_a_outputs", outs_a(), 0);
        check("clr_start_b_outputs", outs_b(), 0);
        repeat (3) @(negedge clock);
        check("clr_start_a_idle", outs_a(), 0);

        // Reset while instance A sits in WAIT: aborted, no pc_load.
        @(negedge clock);
        ir_in   = {9'h0, 4'hF, 19'd3};
        pc_in   = 32'h80;
        con_a   = 1'b1;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("midop_wait_con_en", con_en_a, 1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("midop_reset_outputs", outs_a(), 0);
        repeat (6) @(negedge clock);
        check("midop_still_idle", outs_a(), 0);

        run_a(32'h55, 19'h11, 1'b1, 1'b0);             // recovers normally

        repeat (3) @(negedge clock);
        check("a_load_count", loads_a, exp_loads_a);
        check("b_load_count", loads_b, exp_loads_b);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
